alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_pkg.sv | 41 ++++
 rtl/alu_exec_unit_shifter.sv | 55 +++++
 rtl/alu_exec_unit.sv | 166 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared types for the ALU execute unit: operation codes, FSM states and
// small decode helpers used by the top level and the bench.
package alu_exec_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SLTU = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SUBU = 4'b0111,
    OP_SRL  = 4'b1000,
    OP_SLT  = 4'b1010,
    OP_SRA  = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // True for the three iterative shift operations.
  function automatic logic is_shift(alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // True for any code in the supported operation set.
  function automatic logic is_legal(logic [3:0] code);
    logic ok;
    case (code)
      OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SLL, OP_SLTU,
      OP_SUB, OP_SUBU, OP_SRL, OP_SLT, OP_SRA: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_exec_unit_shifter.sv
// Iterative one-bit-per-cycle shifter. load captures the operand, count and
// direction; each step shifts acc by one bit and decrements the count.
// last_step is high while the pending step is the final one, so the caller
// can register acc_next on that same edge.
module alu_iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   load_value,
  input  logic [SHAMT_W-1:0] load_cnt,
  input  logic               left,
  input  logic               arith,
  output logic [WIDTH-1:0]   acc_next,
  output logic               last_step
);

  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;
  logic               left_q;
  logic               arith_q;

  // Next accumulator value: zero-fill left, zero- or sign-fill right.
  always_comb begin
    acc_next  = acc;
    last_step = (cnt == SHAMT_W'(1));
    if (left_q) begin
      acc_next = {acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {(arith_q & acc[WIDTH-1]), acc[WIDTH-1:1]};
    end
  end

  // Accumulator and count: load on request, advance one bit per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      cnt     <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      acc     <= load_value;
      cnt     <= load_cnt;
      left_q  <= left;
      arith_q <= arith;
    end else if (step && (cnt != '0)) begin
      acc <= acc_next;
      cnt <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit. Single-cycle ops register their result on
// the accept edge; shifts iterate one bit per cycle in alu_iter_shifter.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready
// is high only in IDLE, out_valid only in DONE, so the unit holds exactly one
// operation and never accepts on the edge that retires a result.
import alu_exec_pkg::*;

module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             con_beq,
  input  logic             con_bnq,
  input  logic             con_blt,
  input  logic             con_bgt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branch_taken,
  output logic             illegal_op,
  output state_e           fsm_state
);

  state_e             state;
  alu_op_e            op_in;
  logic               accept;
  logic               legal_in;
  logic               shift_in;
  logic [SHAMT_W-1:0] shamt_in;
  logic               lt_in;
  logic [3:0]         con_in;
  logic [WIDTH-1:0]   alu_res;
  logic               lt_q;
  logic [3:0]         con_q;
  logic               sh_load;
  logic               sh_step;
  logic [WIDTH-1:0]   sh_next;
  logic               sh_last;

  // Branch decision: strobes are ORed, so several set at once is harmless.
  function automatic logic branch_eval(logic z, logic lt, logic [3:0] con);
    return (con[3] & z) | (con[2] & ~z) | (con[1] & lt) | (con[0] & ~lt);
  endfunction

  // Request decode and the single-cycle datapath, evaluated on the inputs.
  always_comb begin
    op_in    = alu_op_e'(operation);
    accept   = in_valid && in_ready;
    legal_in = is_legal(operation);
    shift_in = is_shift(op_in);
    shamt_in = b[SHAMT_W-1:0];
    con_in   = {con_beq, con_bnq, con_blt, con_bgt};
    // Unsigned compare only for SUBU; everything else compares signed.
    lt_in    = (op_in == OP_SUBU) ? (a < b) : ($signed(a) < $signed(b));
    alu_res  = '0;
    case (operation)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_XOR:  alu_res = a ^ b;
      OP_SUB:  alu_res = a - b;
      OP_SUBU: alu_res = a - b;
      OP_SLTU: alu_res = WIDTH'(a < b);
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      // Shifts reach this path only with a zero shift amount.
      OP_SLL, OP_SRL, OP_SRA: alu_res = a;
      default: alu_res = '0;
    endcase
  end

  assign sh_load   = (state == ST_IDLE) && accept && legal_in && shift_in &&
                     (shamt_in != '0);
  assign sh_step   = (state == ST_SHIFT);
  assign fsm_state = state;

  alu_iter_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (sh_load),
    .step       (sh_step),
    .load_value (a),
    .load_cnt   (shamt_in),
    .left       (op_in == OP_SLL),
    .arith      (op_in == OP_SRA),
    .acc_next   (sh_next),
    .last_step  (sh_last)
  );

  // Control FSM with all handshake and result outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      result       <= '0;
      zero         <= 1'b0;
      branch_taken <= 1'b0;
      illegal_op   <= 1'b0;
      lt_q         <= 1'b0;
      con_q        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            lt_q     <= lt_in;
            con_q    <= con_in;
            if (!legal_in) begin
              result       <= '0;
              zero         <= 1'b1;
              branch_taken <= 1'b0;
              illegal_op   <= 1'b1;
              out_valid    <= 1'b1;
              state        <= ST_DONE;
            end else if (shift_in && (shamt_in != '0)) begin
              state <= ST_SHIFT;
            end else begin
              result       <= alu_res;
              zero         <= (alu_res == '0);
              branch_taken <= branch_eval(alu_res == '0, lt_in, con_in);
              illegal_op   <= 1'b0;
              out_valid    <= 1'b1;
              state        <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          if (sh_last) begin
            result       <= sh_next;
            zero         <= (sh_next == '0);
            branch_taken <= branch_eval(sh_next == '0, lt_q, con_q);
            illegal_op   <= 1'b0;
            out_valid    <= 1'b1;
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized
// requests compared against an arithmetic reference model.
import alu_exec_pkg::*;

module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   operation;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         con_beq, con_bnq, con_blt, con_bgt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         branch_taken;
  logic         illegal_op;
  state_e       fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .operation    (operation),
    .a            (a),
    .b            (b),
    .con_beq      (con_beq),
    .con_bnq      (con_bnq),
    .con_blt      (con_blt),
    .con_bgt      (con_bgt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .zero         (zero),
    .branch_taken (branch_taken),
    .illegal_op   (illegal_op),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic model_legal(logic [3:0] op);
    return (op <= 4'd8) || (op == 4'd10) || (op == 4'd12);
  endfunction

  function automatic logic [W-1:0] model_result(logic [3:0] op,
                                                logic [W-1:0] x,
                                                logic [W-1:0] y);
    int sh;
    logic signed [W-1:0] sx;
    sh = int'(y[4:0]);
    sx = x;
    case (op)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x + y;
      4'd3:  return x ^ y;
      4'd4:  return x << sh;
      4'd5:  return (x < y) ? 1 : 0;
      4'd6:  return x - y;
      4'd7:  return x - y;
      4'd8:  return x >> sh;
      4'd10: return ($signed(x) < $signed(y)) ? 1 : 0;
      4'd12: return sx >>> sh;
      default: return 0;
    endcase
  endfunction

  function automatic logic model_branch(logic [3:0] op, logic [W-1:0] x,
                                        logic [W-1:0] y, logic [3:0] con);
    logic z, lt;
    if (!model_legal(op)) return 1'b0;
    z  = (model_result(op, x, y) == 0);
    lt = (op == 4'd7) ? (x < y) : ($signed(x) < $signed(y));
    return (con[3] && z) || (con[2] && !z) || (con[1] && lt) || (con[0] && !lt);
  endfunction

  function automatic int model_latency(logic [3:0] op, logic [W-1:0] y);
    if ((op == 4'd4 || op == 4'd8 || op == 4'd12) && y[4:0] != 0)
      return int'(y[4:0]) + 1;
    return 1;
  endfunction

  // driver: issue one request, check latency and outputs, apply backpressure
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [3:0] con, input int hold);
    int wait_n;
    int lat;
    int exp_lat;
    logic exp_zero, exp_bt, exp_ill;
    logic [W-1:0] exp_res;
    logic [W-1:0] held;

    exp_q.push_back(model_result(op, av, bv));
    exp_lat  = model_latency(op, bv);
    exp_ill  = !model_legal(op);
    exp_bt   = model_branch(op, av, bv, con);

    @(negedge clk);
    operation = op;
    a         = av;
    b         = bv;
    {con_beq, con_bnq, con_blt, con_bgt} = con;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    wait_n = 0;
    while (!in_ready && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    check({tag, "_accept_timeout"}, (wait_n >= 100), 0);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    operation = 4'($urandom_range(0, 15));
    a         = $urandom;
    b         = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);

    exp_res  = exp_q.pop_front();
    exp_zero = (exp_res == 0);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, zero, exp_zero);
    check({tag, "_branch"}, branch_taken, exp_bt);
    check({tag, "_illegal"}, illegal_op, exp_ill);

    // backpressure: outputs hold, new requests are ignored
    held = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check({tag, "_hold_result"}, result, held);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_retire_valid"}, out_valid, 0);
    check({tag, "_retire_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [3:0]   r_op;
    logic [W-1:0] r_a, r_b;
    logic [3:0]   r_con;
    int           rose;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    operation = '0;
    a         = '0;
    b         = '0;
    {con_beq, con_bnq, con_blt, con_bgt} = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_zero", zero, 0);
    check("reset_branch", branch_taken, 0);
    check("reset_illegal", illegal_op, 0);

    // directed cases
    run_op("add_wrap", 4'd2, 32'h7FFF_FFFF, 32'd1, 4'b0000, 0);
    check("add_wrap_const", result, 32'h8000_0000);
    run_op("sub_beq", 4'd6, 32'd5, 32'd5, 4'b1000, 0);
    check("sub_beq_const", branch_taken, 1);
    run_op("sub_bnq", 4'd6, 32'd5, 32'd5, 4'b0100, 0);
    run_op("sub_blt_s", 4'd6, 32'hFFFF_FFFF, 32'd1, 4'b0010, 0);
    check("sub_blt_s_const", branch_taken, 1);
    run_op("subu_blt", 4'd7, 32'hFFFF_FFFF, 32'd1, 4'b0010, 0);
    check("subu_blt_const", branch_taken, 0);
    run_op("sltu", 4'd5, 32'hFFFF_FFFF, 32'd1, 4'b0000, 0);
    run_op("slt", 4'd10, 32'hFFFF_FFFF, 32'd1, 4'b0000, 0);
    check("slt_const", result, 1);
    run_op("sra3", 4'd12, 32'h8000_0000, 32'h23, 4'b0000, 0);
    check("sra3_const", result, 32'hF000_0000);
    run_op("sll0", 4'd4, 32'h1234_5678, 32'h20, 4'b0000, 0);
    run_op("srl31", 4'd8, 32'h8000_0000, 32'd31, 4'b0000, 0);
    check("srl31_const", result, 1);
    run_op("bp_xor", 4'd3, 32'hA5A5_0000, 32'h0F0F_0F0F, 4'b0001, 5);
    run_op("after_bp", 4'd1, 32'h0000_00F0, 32'h0000_000F, 4'b0000, 0);
    run_op("illegal", 4'd15, 32'd7, 32'd7, 4'b1111, 0);
    check("illegal_const", illegal_op, 1);
    run_op("legal_after", 4'd0, 32'hFF00, 32'h0FF0, 4'b0000, 0);

    // reset during a shift: the aborted op never presents a result
    @(negedge clk);
    operation = 4'd8;
    a         = 32'h8000_0000;
    b         = 32'd20;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rose  = 0;
    check("abort_in_ready", in_ready, 1);
    check("abort_result", result, 0);
    check("abort_zero", zero, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) rose = 1;
    end
    check("abort_never_valid", rose, 0);
    run_op("post_abort", 4'd2, 32'd3, 32'd4, 4'b0000, 0);

    // randomized requests
    for (int n = 0; n < 150; n++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = r_a;
        1:       r_b = 32'($urandom_range(0, 40));
        default: r_b = $urandom;
      endcase
      case ($urandom_range(0, 2))
        0:       r_con = 4'b0001 << $urandom_range(0, 3);
        1:       r_con = 4'($urandom_range(0, 15));
        default: r_con = 4'b0000;
      endcase
      run_op("rand", r_op, r_a, r_b, r_con, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
